// File: rtl/hazard_forward_ctrl.sv
// Hazard detection, operand forwarding and pipeline hold control with multi-cycle
// load-use bubbles, data-memory wait handling, deferred kills and stall/flush counters.
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W  = 3,
    parameter int NUM_SRC     = 2,
    parameter int LOAD_LAT    = 1,
    parameter int ZERO_REG_EN = 1,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic [REG_ADDR_W-1:0]         mem_rd,
    input  logic [REG_ADDR_W-1:0]         wb_rd,
    input  logic                          ex_regwr,
    input  logic                          mem_regwr,
    input  logic                          wb_regwr,
    input  logic                          ex_memrd,
    input  logic                          mem_busy,
    input  logic                          kill,
    input  logic                          clr_cnt,
    output logic [NUM_SRC*2-1:0]          forward,
    output logic                          stall,
    output logic                          bubble,
    output logic                          freeze,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              flush_cnt,
    output logic [1:0]                    state
);

    generate
        if ((LOAD_LAT < 1) || (LOAD_LAT > 3)) begin : g_bad_load_lat
            $error("hazard_forward_ctrl: LOAD_LAT must lie in 1..3");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HOLD_LOAD = 2'd1,
        ST_HOLD_MEM  = 2'd2
    } state_t;

    localparam logic [1:0] LOAD_INIT = 2'(LOAD_LAT - 1);

    state_t               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 kill_pend_q, kill_pend_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic [NUM_SRC*2-1:0] fwd_s;
    logic                 hazard_s;
    logic                 stall_s;
    logic                 bubble_s;
    logic                 freeze_s;
    logic                 kill_apply_s;

    function automatic logic src_match(input logic                  used,
                                       input logic [REG_ADDR_W-1:0] rs,
                                       input logic [REG_ADDR_W-1:0] rd,
                                       input logic                  regwr);
        logic zero_blocked;
        zero_blocked = (ZERO_REG_EN != 0) && (rs == {REG_ADDR_W{1'b0}});
        src_match    = used && regwr && (rs == rd) && !zero_blocked;
    endfunction

    // Per-source forward select (EX > MEM > WB) and load-use detection
    always_comb begin
        logic [REG_ADDR_W-1:0] rs_s;
        fwd_s    = {(NUM_SRC*2){1'b0}};
        hazard_s = 1'b0;
        rs_s     = {REG_ADDR_W{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            rs_s = id_rs[i*REG_ADDR_W +: REG_ADDR_W];
            if (src_match(id_rs_used[i], rs_s, ex_rd, ex_regwr)) begin
                fwd_s[i*2 +: 2] = 2'd1;
                if (id_valid && ex_memrd) begin
                    hazard_s = 1'b1;
                end else begin
                    hazard_s = hazard_s;
                end
            end else if (src_match(id_rs_used[i], rs_s, mem_rd, mem_regwr)) begin
                fwd_s[i*2 +: 2] = 2'd2;
            end else if (src_match(id_rs_used[i], rs_s, wb_rd, wb_regwr)) begin
                fwd_s[i*2 +: 2] = 2'd3;
            end else begin
                fwd_s[i*2 +: 2] = 2'd0;
            end
        end
    end

    // Control FSM: next state, bubble counter, kill deferral and pipeline controls
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        kill_pend_d  = kill_pend_q;
        stall_s      = 1'b0;
        bubble_s     = 1'b0;
        freeze_s     = 1'b0;
        kill_apply_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    freeze_s    = 1'b1;
                    stall_s     = 1'b1;
                    state_d     = ST_HOLD_MEM;
                    kill_pend_d = kill_pend_q | kill;
                end else if (kill) begin
                    bubble_s     = 1'b1;
                    kill_apply_s = 1'b1;
                end else if (hazard_s) begin
                    stall_s  = 1'b1;
                    bubble_s = 1'b1;
                    cnt_d    = LOAD_INIT;
                    state_d  = (LOAD_LAT > 1) ? ST_HOLD_LOAD : ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HOLD_LOAD: begin
                // A memory wait freezes the pipe, so no bubble is consumed that cycle.
                if (mem_busy) begin
                    freeze_s    = 1'b1;
                    stall_s     = 1'b1;
                    state_d     = ST_HOLD_MEM;
                    kill_pend_d = kill_pend_q | kill;
                end else if (kill) begin
                    bubble_s     = 1'b1;
                    kill_apply_s = 1'b1;
                    cnt_d        = 2'd0;
                    state_d      = ST_RUN;
                end else begin
                    stall_s  = 1'b1;
                    bubble_s = 1'b1;
                    cnt_d    = cnt_q - 2'd1;
                    state_d  = (cnt_q <= 2'd1) ? ST_RUN : ST_HOLD_LOAD;
                end
            end
            ST_HOLD_MEM: begin
                if (mem_busy) begin
                    freeze_s    = 1'b1;
                    stall_s     = 1'b1;
                    kill_pend_d = kill_pend_q | kill;
                end else if (kill_pend_q || kill) begin
                    bubble_s     = 1'b1;
                    kill_apply_s = 1'b1;
                    kill_pend_d  = 1'b0;
                    cnt_d        = 2'd0;
                    state_d      = ST_RUN;
                end else if (cnt_q != 2'd0) begin
                    // Keep the dependent instruction parked while the load resumes.
                    stall_s  = 1'b1;
                    bubble_s = 1'b1;
                    state_d  = ST_HOLD_LOAD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d     = ST_RUN;
                cnt_d       = 2'd0;
                kill_pend_d = 1'b0;
            end
        endcase
    end

    // Saturating stall/flush counters with clear priority
    always_comb begin
        if (clr_cnt) begin
            stall_cnt_d = {CNT_W{1'b0}};
            flush_cnt_d = {CNT_W{1'b0}};
        end else begin
            if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (kill_apply_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end
    end

    // State, counter and deferred-kill registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= 2'd0;
            kill_pend_q <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            kill_pend_q <= kill_pend_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign forward   = reset ? {(NUM_SRC*2){1'b0}} : fwd_s;
    assign stall     = stall_s & ~reset;
    assign bubble    = bubble_s & ~reset;
    assign freeze    = freeze_s & ~reset;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign state     = state_q;

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Parametrised successor to the pipeline hazard/forwarding logic.
- Sits between decode and the EX/MEM/WB pipeline registers and drives these outputs:
  - per-source forward-mux selects;
  - PC/IF-ID hold (stall);
  - ID/EX bubble insertion (bubble);
  - whole-pipeline freeze (freeze).
- Adds state the earlier logic lacks:
  - multi-cycle load-use stall via a bubble counter;
  - data-memory wait handling;
  - kill deferral across a freeze;
  - saturating stall and flush performance counters.

Parameters:
- REG_ADDR_W, 3, register-index width.
- NUM_SRC, 2, number of source operands per instruction.
- LOAD_LAT, 1, bubbles per load-use hazard. Legal range 1..3; any other value is an elaboration error.
- ZERO_REG_EN, 1, when 1, register index 0 is never forwarded and never causes a hazard.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs  in  NUM_SRC*REG_ADDR_W  source indices; source i occupies bits [i*REG_ADDR_W +: REG_ADDR_W].
- id_rs_used  in  NUM_SRC  per-source "operand actually read".
- ex_rd, mem_rd, wb_rd  in  REG_ADDR_W each  destination index per stage.
- ex_regwr, mem_regwr, wb_regwr  in  1 each  stage writes the register file.
- ex_memrd  in  1  EX instruction is a load.
- mem_busy  in  1  data memory not ready.
- kill  in  1  taken branch/jump/ret; flush the instruction in decode.
- clr_cnt  in  1  synchronous clear of both counters.
- forward  out  NUM_SRC*2  per-source select: 0 regfile, 1 EX, 2 MEM, 3 WB.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  load a NOP into ID/EX.
- freeze  out  1  hold every pipeline register.
- stall_cnt  out  CNT_W  count of cycles with stall=1.
- flush_cnt  out  CNT_W  count of applied kills.
- state  out  2  encoding 0 RUN, 1 HOLD_LOAD, 2 HOLD_MEM.

Behaviour:
- Reset (asynchronous): state=RUN, bubble counter=0, kill_pend=0, stall_cnt=0, flush_cnt=0. All outputs are 0 while reset is high.
- Forwarding (combinational, every cycle, in every state):
  - For each source i, matching a stage requires all of: id_rs_used[i]; the index is non-zero (when ZERO_REG_EN=1); the index equals that stage's rd; that stage's regwr=1.
  - Priority EX > MEM > WB.
  - Result is 0 if no stage matches.
- Load-use hazard: id_valid & ex_memrd & ex_regwr & some used source matches ex_rd (zero rule applies).
- RUN:
  - If mem_busy: freeze=1, stall=1, bubble=0; next state HOLD_MEM. If kill is also high, set kill_pend.
  - Else if kill: bubble=1, stall=0; flush_cnt+1; stay RUN. kill beats the load-use hazard.
  - Else if hazard: stall=1, bubble=1, counter=LOAD_LAT-1. Next state is HOLD_LOAD if LOAD_LAT>1, else RUN.
  - Else: all controls 0.
- HOLD_LOAD: stall=1 and bubble=1 regardless of the comparators. Counter decrements each cycle; on the cycle it reads 1, the next state is RUN. Exits in priority order:
  - mem_busy: go to HOLD_MEM; the remaining count is preserved and resumed on return.
  - kill: abort; counter=0, stall=0, bubble=1, flush_cnt+1, next state RUN.
- HOLD_MEM: freeze=1, stall=1, bubble=0. A kill in this state sets kill_pend and is not applied.
  - When mem_busy falls: if kill_pend, apply the kill that same cycle (bubble=1, flush_cnt+1, clear kill_pend) and go to RUN.
  - Otherwise return to HOLD_LOAD if the counter is non-zero, else to RUN.
- Counters:
  - Each increments by 1 per qualifying cycle and saturates at all-ones.
  - clr_cnt takes priority over increment; the counters read 0 on the next cycle.
- Reset asserted mid-stall clears all state immediately; there is no residual bubble after reset deasserts.
- Latency: stall, bubble and freeze are combinational from the inputs plus the registered state, valid in the same cycle.

Test Plan:
- ex_rd=3, ex_regwr=1, mem_rd=3, mem_regwr=1, id_rs0=3 used, no load -> forward[1:0]=1, stall=0.
- LOAD_LAT=2, load in EX with rd=2, id_rs1=2 used -> stall=bubble=1 for exactly 2 cycles, state RUN→HOLD_LOAD→RUN, stall_cnt=2.
- id_rs0=0, ex_rd=0, ex_regwr=1, ZERO_REG_EN=1 -> forward=0, no stall even if ex_memrd=1.
- Load-use hazard and kill in the same cycle -> bubble=1, stall=0, flush_cnt+1, state stays RUN.
- mem_busy high 3 cycles with kill in cycle 2 -> freeze=1 for 3 cycles, then bubble=1 on the release cycle, flush_cnt=1.
- stall_cnt preset near all-ones (CNT_W=4, 16 stall cycles) -> holds at 15; clr_cnt -> reads 0 the next cycle. Reset asserted during HOLD_LOAD -> all outputs 0 asynchronously.
